// File: rtl/dctq_frame_sched.sv
// Frame-level sequencer for the DCTQ core. It streams 8-row blocks from the frame buffer
// into the DCTQ input buffer, starts each block, and counts completed blocks until the frame is done.
module dctq_frame_sched #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 13,
    parameter int BLK_W  = 11
) (
    input  logic              pci_clk,
    input  logic              reset_n,
    input  logic              frame_go,
    input  logic              frame_abort,
    input  logic [BLK_W-1:0]  num_blks,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] di,
    output logic              din_valid,
    output logic [2:0]        wa,
    output logic [7:0]        be,
    input  logic              ready,
    output logic              start,
    input  logic              dctq_valid,
    input  logic [5:0]        addr,
    output logic              busy,
    output logic              done,
    output logic [BLK_W-1:0]  blk_cnt,
    output logic [BLK_W-1:0]  eob_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        ARM,
        WAIT_EOB,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              din_valid_q, din_valid_d;
    logic [2:0]        wa_q, wa_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0]  eob_cnt_q, eob_cnt_d;
    logic [BLK_W-1:0]  num_blks_q, num_blks_d;

    logic rd_issue;
    logic start_fire;
    logic eob_hit;
    logic din_live;

    // Abort wins over every event, so it masks reads, starts and returning data in its own cycle.
    assign rd_issue   = (state_q == LOAD) && !hold && !frame_abort;
    assign start_fire = (state_q == ARM) && ready && !frame_abort;
    assign eob_hit    = (state_q != IDLE) && dctq_valid && (addr == 6'd63)
                        && (eob_cnt_q < num_blks_q);
    assign din_live   = din_valid_q && !frame_abort;

    always_ff @(posedge pci_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            mem_addr_q  <= '0;
            din_valid_q <= 1'b0;
            wa_q        <= '0;
            blk_cnt_q   <= '0;
            eob_cnt_q   <= '0;
            num_blks_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            mem_addr_q  <= mem_addr_d;
            din_valid_q <= din_valid_d;
            wa_q        <= wa_d;
            blk_cnt_q   <= blk_cnt_d;
            eob_cnt_q   <= eob_cnt_d;
            num_blks_q  <= num_blks_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        mem_addr_d  = mem_addr_q;
        din_valid_d = 1'b0;
        wa_d        = wa_q;
        blk_cnt_d   = blk_cnt_q;
        eob_cnt_d   = eob_cnt_q;
        num_blks_d  = num_blks_q;

        if (frame_abort) begin
            state_d    = IDLE;
            row_d      = '0;
            mem_addr_d = '0;
            wa_d       = '0;
            blk_cnt_d  = '0;
            eob_cnt_d  = '0;
            num_blks_d = '0;
        end else begin
            din_valid_d = rd_issue;
            if (rd_issue) begin
                wa_d       = row_q;
                row_d      = row_q + 3'd1;
                mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
            if (eob_hit) begin
                eob_cnt_d = eob_cnt_q + BLK_W'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (frame_go) begin
                        num_blks_d = num_blks;
                        mem_addr_d = base_addr;
                        row_d      = '0;
                        blk_cnt_d  = '0;
                        eob_cnt_d  = '0;
                        state_d    = (num_blks == '0) ? FIN : LOAD;
                    end
                end
                LOAD: begin
                    if (rd_issue && (row_q == 3'd7)) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: state_d = ARM;
                ARM: begin
                    if (start_fire) begin
                        blk_cnt_d = blk_cnt_q + BLK_W'(1);
                        state_d   = ((blk_cnt_q + BLK_W'(1)) < num_blks_q) ? LOAD : WAIT_EOB;
                    end
                end
                WAIT_EOB: begin
                    if (eob_cnt_q == num_blks_q) begin
                        state_d = FIN;
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign mem_rd    = rd_issue;
    assign mem_addr  = mem_addr_q;
    assign din_valid = din_live;
    assign di        = din_live ? mem_rdata : '0;
    assign wa        = wa_q;
    assign be        = din_live ? 8'hFF : 8'h00;
    assign start     = start_fire;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN) && !frame_abort;
    assign blk_cnt   = blk_cnt_q;
    assign eob_cnt   = eob_cnt_q;

endmodule

// File: tb/tb_dctq_frame_sched.sv
// Scoreboard bench for dctq_frame_sched: stimulus queues expected reads, rows, starts and
// done pulses; a negedge monitor pops and compares them as the sequencer produces them.
module tb_dctq_frame_sched;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 13;
    localparam int BLK_W  = 11;

    logic              pci_clk;
    logic              reset_n;
    logic              frame_go;
    logic              frame_abort;
    logic [BLK_W-1:0]  num_blks;
    logic [ADDR_W-1:0] base_addr;
    logic              hold;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] di;
    logic              din_valid;
    logic [2:0]        wa;
    logic [7:0]        be;
    logic              ready;
    logic              start;
    logic              dctq_valid;
    logic [5:0]        addr;
    logic              busy;
    logic              done;
    logic [BLK_W-1:0]  blk_cnt;
    logic [BLK_W-1:0]  eob_cnt;

    dctq_frame_sched #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .BLK_W (BLK_W)
    ) dut (
        .pci_clk    (pci_clk),
        .reset_n    (reset_n),
        .frame_go   (frame_go),
        .frame_abort(frame_abort),
        .num_blks   (num_blks),
        .base_addr  (base_addr),
        .hold       (hold),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .di         (di),
        .din_valid  (din_valid),
        .wa         (wa),
        .be         (be),
        .ready      (ready),
        .start      (start),
        .dctq_valid (dctq_valid),
        .addr       (addr),
        .busy       (busy),
        .done       (done),
        .blk_cnt    (blk_cnt),
        .eob_cnt    (eob_cnt)
    );

    typedef struct {
        logic [2:0]        wa;
        logic [DATA_W-1:0] data;
    } din_t;

    logic [ADDR_W-1:0] exp_rd[$];
    din_t              exp_din[$];
    int                exp_start[$];
    int                exp_done[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int go_cyc = 0;
    int rd_seen = 0;
    int din_seen = 0;
    int start_seen = 0;
    int done_seen = 0;
    int last_start_cyc = 0;
    int last_done_cyc = 0;
    logic [ADDR_W-1:0] last_rd_addr = '0;
    int coef_len = 1;
    bit hold_mode = 1'b0;

    initial begin
        pci_clk = 1'b0;
        forever #5 pci_clk = ~pci_clk;
    end

    initial begin
        forever begin
            @(posedge pci_clk);
            cyc++;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DATA_W-1:0] memfn(input logic [ADDR_W-1:0] a);
        return {~a, a, 6'h2B, a, ~a, 6'h15};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: output seen with nothing expected at cycle %0d", name, cyc);
    endtask

    // Frame buffer: answers every read exactly one cycle later.
    initial begin
        logic              rd_pend;
        logic [ADDR_W-1:0] rd_a;
        mem_rdata = '0;
        forever begin
            @(negedge pci_clk);
            rd_pend = mem_rd;
            rd_a    = mem_addr;
            @(posedge pci_clk);
            #1;
            mem_rdata = rd_pend ? memfn(rd_a) : 64'h0BAD_F00D_DEAD_BEEF;
        end
    end

    initial begin
        hold = 1'b0;
        forever begin
            @(posedge pci_clk);
            #1;
            hold = hold_mode ? ~hold : 1'b0;
        end
    end

    // DCTQ core stand-in: each start yields a coefficient run ending at index 63.
    initial begin
        int pend = 0;
        int left = 0;
        dctq_valid = 1'b0;
        addr = '0;
        forever begin
            @(negedge pci_clk);
            if (start === 1'b1) pend++;
            @(posedge pci_clk);
            #1;
            if (left == 0 && pend > 0) begin
                pend--;
                left = coef_len;
            end
            if (left > 0) begin
                dctq_valid = 1'b1;
                addr = 6'(64 - left);
                left--;
            end else begin
                dctq_valid = 1'b0;
                addr = '0;
            end
        end
    end

    initial begin
        din_t d;
        forever begin
            @(negedge pci_clk);
            if (reset_n) begin
                if (mem_rd) begin
                    rd_seen++;
                    last_rd_addr = mem_addr;
                    if (exp_rd.size() == 0) reportUnexpected("mem_rd");
                    else checkOutput("mem_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
                end
                if (din_valid) begin
                    din_seen++;
                    if (exp_din.size() == 0) reportUnexpected("din_valid");
                    else begin
                        d = exp_din.pop_front();
                        checkOutput("wa", 64'(wa), 64'(d.wa));
                        checkOutput("di", di, d.data);
                        checkOutput("be", 64'(be), 64'hFF);
                    end
                end
                if (start) begin
                    start_seen++;
                    last_start_cyc = cyc;
                    if (exp_start.size() == 0) reportUnexpected("start");
                    else checkOutput("blk_cnt at start", 64'(blk_cnt), 64'(exp_start.pop_front()));
                end
                if (done) begin
                    done_seen++;
                    last_done_cyc = cyc;
                    if (exp_done.size() == 0) reportUnexpected("done");
                    else begin
                        d.wa = '0;
                        begin
                            int n;
                            n = exp_done.pop_front();
                            checkOutput("blk_cnt at done", 64'(blk_cnt), 64'(n));
                            checkOutput("eob_cnt at done", 64'(eob_cnt), 64'(n));
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+1; pulses frame_go and optionally queues a full frame's expectations.
    task automatic applyStimulus(input int n, input int base, input bit push_all);
        logic [ADDR_W-1:0] a;
        din_t d;
        if (push_all) begin
            for (int b = 0; b < n; b++) begin
                for (int r = 0; r < 8; r++) begin
                    a = ADDR_W'(base + b * 8 + r);
                    exp_rd.push_back(a);
                    d.wa = 3'(r);
                    d.data = memfn(a);
                    exp_din.push_back(d);
                end
                exp_start.push_back(b);
            end
            exp_done.push_back(n);
        end
        num_blks  = BLK_W'(n);
        base_addr = ADDR_W'(base);
        frame_go  = 1'b1;
        go_cyc    = cyc;
        @(posedge pci_clk);
        #1;
        frame_go = 1'b0;
    endtask

    task automatic waitIdle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            @(posedge pci_clk);
            #1;
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: busy still 1 after %0d cycles, expected 0", name, limit);
        end
    endtask

    initial begin
        int rd0, din0, st0, dn0, n;
        din_t d;
        reset_n     = 1'b0;
        frame_go    = 1'b0;
        frame_abort = 1'b0;
        num_blks    = '0;
        base_addr   = '0;
        ready       = 1'b1;
        repeat (3) @(posedge pci_clk);
        #1;

        checkOutput("reset mem_rd", 64'(mem_rd), 0);
        checkOutput("reset mem_addr", 64'(mem_addr), 0);
        checkOutput("reset din_valid", 64'(din_valid), 0);
        checkOutput("reset di", di, 0);
        checkOutput("reset wa", 64'(wa), 0);
        checkOutput("reset be", 64'(be), 0);
        checkOutput("reset start", 64'(start), 0);
        checkOutput("reset busy", 64'(busy), 0);
        checkOutput("reset done", 64'(done), 0);
        checkOutput("reset blk_cnt", 64'(blk_cnt), 0);
        checkOutput("reset eob_cnt", 64'(eob_cnt), 0);

        $display("[TB] single block, full coefficient run, go in reset-release cycle");
        coef_len = 64;
        din0 = din_seen;
        reset_n = 1'b1;
        applyStimulus(1, 0, 1'b1);
        waitIdle(300, "t1 idle");
        checkOutput("t1 go to start cycles", 64'(last_start_cyc - go_cyc), 10);
        checkOutput("t1 din_valid count", 64'(din_seen - din0), 8);
        checkOutput("t1 eob_cnt", 64'(eob_cnt), 1);
        checkOutput("t1 blk_cnt", 64'(blk_cnt), 1);
        coef_len = 1;

        $display("[TB] hold toggling during load, address wrap");
        hold_mode = 1'b1;
        din0 = din_seen;
        applyStimulus(1, 8188, 1'b1);
        waitIdle(300, "t4 idle");
        hold_mode = 1'b0;
        checkOutput("t4 din_valid count", 64'(din_seen - din0), 8);

        $display("[TB] ready held low");
        ready = 1'b0;
        rd0 = rd_seen;
        st0 = start_seen;
        applyStimulus(2, 200, 1'b1);
        repeat (50) @(posedge pci_clk);
        #1;
        checkOutput("t3 no start while not ready", 64'(start_seen - st0), 0);
        checkOutput("t3 reads while stalled", 64'(rd_seen - rd0), 8);
        checkOutput("t3 busy while stalled", 64'(busy), 1);
        ready = 1'b1;
        #1;
        checkOutput("t3 start on ready", 64'(start), 1);
        waitIdle(300, "t3 idle");

        $display("[TB] abort during block 3 load");
        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r < 8; r++) begin
                exp_rd.push_back(ADDR_W'(256 + b * 8 + r));
                d.wa = 3'(r);
                d.data = memfn(ADDR_W'(256 + b * 8 + r));
                exp_din.push_back(d);
            end
            exp_start.push_back(b);
        end
        exp_rd.push_back(ADDR_W'(256 + 24));
        exp_rd.push_back(ADDR_W'(256 + 25));
        d.wa = 3'd0;
        d.data = memfn(ADDR_W'(256 + 24));
        exp_din.push_back(d);
        dn0 = done_seen;
        applyStimulus(6, 256, 1'b0);
        n = 0;
        while (blk_cnt != BLK_W'(3) && n < 200) begin
            @(posedge pci_clk);
            #1;
            n++;
        end
        if (blk_cnt != BLK_W'(3)) begin
            tests++;
            fails++;
            $display("[TB] FAIL t5 reach block 3: blk_cnt 0x%0h, expected 0x3", blk_cnt);
        end
        repeat (2) @(posedge pci_clk);
        #1;
        frame_abort = 1'b1;
        @(posedge pci_clk);
        #1;
        frame_abort = 1'b0;
        checkOutput("t5 busy after abort", 64'(busy), 0);
        checkOutput("t5 din_valid after abort", 64'(din_valid), 0);
        checkOutput("t5 blk_cnt after abort", 64'(blk_cnt), 0);
        checkOutput("t5 eob_cnt after abort", 64'(eob_cnt), 0);
        checkOutput("t5 mem_addr after abort", 64'(mem_addr), 0);
        checkOutput("t5 mem_rd after abort", 64'(mem_rd), 0);
        repeat (3) @(posedge pci_clk);
        #1;
        checkOutput("t5 no done on abort", 64'(done_seen - dn0), 0);
        applyStimulus(2, 256, 1'b1);
        waitIdle(300, "t5 restart idle");
        checkOutput("t5 restart eob_cnt", 64'(eob_cnt), 2);

        $display("[TB] zero-block frame, go while busy");
        rd0 = rd_seen;
        applyStimulus(0, 5, 1'b1);
        waitIdle(20, "t6 idle");
        checkOutput("t6 go to done cycles", 64'(last_done_cyc - go_cyc), 1);
        checkOutput("t6 no reads", 64'(rd_seen - rd0), 0);
        applyStimulus(2, 50, 1'b1);
        repeat (3) @(posedge pci_clk);
        #1;
        num_blks  = BLK_W'(7);
        base_addr = '0;
        frame_go  = 1'b1;
        @(posedge pci_clk);
        #1;
        frame_go = 1'b0;
        waitIdle(300, "t6 busy-go idle");
        checkOutput("t6 blk_cnt ignores busy go", 64'(blk_cnt), 2);

        $display("[TB] full 1024-block frame");
        dn0 = done_seen;
        rd0 = rd_seen;
        applyStimulus(1024, 0, 1'b1);
        waitIdle(20000, "t2 idle");
        checkOutput("t2 reads", 64'(rd_seen - rd0), 8192);
        checkOutput("t2 last mem_addr", 64'(last_rd_addr), 8191);
        checkOutput("t2 blk_cnt", 64'(blk_cnt), 1024);
        checkOutput("t2 eob_cnt", 64'(eob_cnt), 1024);
        checkOutput("t2 done count", 64'(done_seen - dn0), 1);

        repeat (5) @(posedge pci_clk);
        #1;
        checkOutput("leftover reads", 64'(exp_rd.size()), 0);
        checkOutput("leftover rows", 64'(exp_din.size()), 0);
        checkOutput("leftover starts", 64'(exp_start.size()), 0);
        checkOutput("leftover dones", 64'(exp_done.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
